// File: rtl/ps2_key_decoder_if.sv
// PS/2 receive FIFO pop handshake: head byte, non-empty flag and active-low pop strobe.
interface ps2_key_decoder_if;
    logic       ready;
    logic [7:0] data;
    logic       nextdata_n;

    modport master (output ready, output data, input nextdata_n);
    modport slave  (input ready, input data, output nextdata_n);
endinterface

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 make/break/E0 byte streams into held-key state, press events and a press count.
// Optional macro PS2DEC_SHIFT_EN tracks left/right shift separately from the held key.
module ps2_key_decoder #(
    parameter int unsigned CNT_W   = 8,
    parameter logic [7:0]  SHIFT_L = 8'h12,
    parameter logic [7:0]  SHIFT_R = 8'h59
) (
    input  logic             clk,
    input  logic             clrn,
    ps2_key_decoder_if.slave fifo,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             key_event,
    output logic [CNT_W-1:0] press_count,
    output logic             shift
);

    typedef enum logic {IDLE, POP} state_t;

    state_t state;
    logic   brk;
    logic   ext;
    logic   hit;
    logic   is_shift;

    // Byte names the currently held key, with the same E0 qualification.
    assign hit = key_down && (fifo.data == key_code) && (ext == key_ext);

`ifdef PS2DEC_SHIFT_EN
    logic shift_l;
    logic shift_r;
    assign is_shift = (fifo.data == SHIFT_L) || (fifo.data == SHIFT_R);
    assign shift    = shift_l | shift_r;
`else
    assign is_shift = 1'b0;
    assign shift    = 1'b0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state           <= IDLE;
            fifo.nextdata_n <= 1'b1;
            brk             <= 1'b0;
            ext             <= 1'b0;
            key_code        <= 8'h00;
            key_ext         <= 1'b0;
            key_down        <= 1'b0;
            key_event       <= 1'b0;
            press_count     <= '0;
`ifdef PS2DEC_SHIFT_EN
            shift_l         <= 1'b0;
            shift_r         <= 1'b0;
`endif
        end else begin
            key_event <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fifo.ready) begin
                        state           <= POP;
                        fifo.nextdata_n <= 1'b0;
                    end
                end
                POP: begin
                    state           <= IDLE;
                    fifo.nextdata_n <= 1'b1;
                    if (fifo.data == 8'hE0) begin
                        ext <= 1'b1;
                    end else if (fifo.data == 8'hF0) begin
                        brk <= 1'b1;
                    end else begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                        if (is_shift) begin
`ifdef PS2DEC_SHIFT_EN
                            if (fifo.data == SHIFT_L) shift_l <= ~brk;
                            else                      shift_r <= ~brk;
`endif
                        end else if (brk) begin
                            if (hit) begin
                                key_down  <= 1'b0;
                                key_event <= 1'b1;
                            end
                        end else if (!hit) begin
                            // A different key replaces whatever was held.
                            key_code    <= fifo.data;
                            key_ext     <= ext;
                            key_down    <= 1'b1;
                            press_count <= press_count + 1'b1;
                            key_event   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: FIFO model, vector table and event scoreboard.
module tb_ps2_key_decoder;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       down;
        logic [7:0] cnt;
        logic       sh;
    } vec_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       down;
        logic [7:0] cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic       key_event;
    logic [7:0] press_count;
    logic       shift;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .CNT_W  (8),
        .SHIFT_L(8'h12),
        .SHIFT_R(8'h59)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .fifo       (bus.slave),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .key_event  (key_event),
        .press_count(press_count),
        .shift      (shift)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         pops = 0;
    int         lows = 0;
    logic [7:0] q[$];
    logic [7:0] popped[$];
    ev_t        exp_q[$];
    vec_t       tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic void add(input logic [7:0] b, input logic ev, input logic [7:0] code,
                                input logic ext, input logic down, input logic [7:0] cnt,
                                input logic sh);
        vec_t v;
        v.b = b; v.ev = ev; v.code = code; v.ext = ext; v.down = down; v.cnt = cnt; v.sh = sh;
        tbl.push_back(v);
    endfunction

    function automatic void push(input logic [7:0] b, input logic ev, input logic [7:0] code,
                                 input logic ext, input logic down, input logic [7:0] cnt);
        ev_t e;
        q.push_back(b);
        if (ev) begin
            e.code = code; e.ext = ext; e.down = down; e.cnt = cnt;
            exp_q.push_back(e);
        end
    endfunction

    // FIFO model: owns the bus, pops the head on the edge that ends a low nextdata_n cycle.
    initial begin : fifo_model
        logic pend;
        logic prev_low;
        prev_low = 1'b0;
        bus.ready = 1'b0;
        bus.data  = 8'h00;
        forever begin
            @(negedge clk);
            pend = !bus.nextdata_n;
            if (pend) begin
                lows++;
                checks++;
                if (prev_low) begin
                    errors++;
                    $display("FAIL nextdata_n_consecutive: got low twice, expected high between pops");
                end
            end
            prev_low = pend;
            #1;
            bus.ready = (q.size() != 0);
            bus.data  = (q.size() != 0) ? q[0] : 8'h00;
            @(posedge clk);
            #1;
            if (pend && clrn && q.size() != 0) begin
                popped.push_back(q.pop_front());
                pops++;
            end
            bus.ready = (q.size() != 0);
            bus.data  = (q.size() != 0) ? q[0] : 8'h00;
        end
    end

    // Event scoreboard.
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (clrn && key_event) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL event_unexpected: got key_event code %h, expected none", key_code);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_state", {key_code, key_ext, key_down, press_count}, e);
                end
            end
        end
    end

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("fifo_drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("reset_state", {key_code, key_ext, key_down, key_event, press_count, shift,
                            bus.nextdata_n}, {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        clrn = 1'b1;
    endtask

    initial begin : main
        int n;
        int p0;
        int l0;
        logic [7:0] hs[6];
        logic [7:0] code;

        // byte, event, key_code, key_ext, key_down, press_count, shift
        add(8'h1C, 1, 8'h1C, 0, 1, 1, 0);
        add(8'hF0, 0, 8'h1C, 0, 1, 1, 0);
        add(8'h1C, 1, 8'h1C, 0, 0, 1, 0);
        add(8'h1C, 1, 8'h1C, 0, 1, 2, 0);
        add(8'h1C, 0, 8'h1C, 0, 1, 2, 0);
        add(8'h1C, 0, 8'h1C, 0, 1, 2, 0);
        add(8'hF0, 0, 8'h1C, 0, 1, 2, 0);
        add(8'h1C, 1, 8'h1C, 0, 0, 2, 0);
        add(8'hE0, 0, 8'h1C, 0, 0, 2, 0);
        add(8'h75, 1, 8'h75, 1, 1, 3, 0);
        add(8'hF0, 0, 8'h75, 1, 1, 3, 0);
        add(8'h75, 0, 8'h75, 1, 1, 3, 0);
        add(8'hE0, 0, 8'h75, 1, 1, 3, 0);
        add(8'hF0, 0, 8'h75, 1, 1, 3, 0);
        add(8'h75, 1, 8'h75, 1, 0, 3, 0);
        add(8'h1C, 1, 8'h1C, 0, 1, 4, 0);
        add(8'h32, 1, 8'h32, 0, 1, 5, 0);
        add(8'hF0, 0, 8'h32, 0, 1, 5, 0);
        add(8'h1C, 0, 8'h32, 0, 1, 5, 0);
        add(8'hF0, 0, 8'h32, 0, 1, 5, 0);
        add(8'h32, 1, 8'h32, 0, 0, 5, 0);
`ifdef PS2DEC_SHIFT_EN
        add(8'h12, 0, 8'h32, 0, 0, 5, 1);
        add(8'h1C, 1, 8'h1C, 0, 1, 6, 1);
        add(8'hF0, 0, 8'h1C, 0, 1, 6, 1);
        add(8'h12, 0, 8'h1C, 0, 1, 6, 0);
`else
        add(8'h12, 1, 8'h12, 0, 1, 6, 0);
        add(8'h1C, 1, 8'h1C, 0, 1, 7, 0);
        add(8'hF0, 0, 8'h1C, 0, 1, 7, 0);
        add(8'h12, 0, 8'h1C, 0, 1, 7, 0);
`endif

        do_reset();

        foreach (tbl[i]) begin
            push(tbl[i].b, tbl[i].ev, tbl[i].code, tbl[i].ext, tbl[i].down, tbl[i].cnt);
            wait_empty(40);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {key_code, key_ext, key_down, press_count, shift},
                {tbl[i].code, tbl[i].ext, tbl[i].down, tbl[i].cnt, tbl[i].sh});
        end
        repeat (3) @(negedge clk);

        // Back-to-back handshake with ready held high.
        do_reset();
        hs[0] = 8'h1C; hs[1] = 8'hF0; hs[2] = 8'h1C;
        hs[3] = 8'h32; hs[4] = 8'hF0; hs[5] = 8'h32;
        p0 = pops;
        l0 = lows;
        push(hs[0], 1, 8'h1C, 0, 1, 1);
        push(hs[1], 0, 8'h00, 0, 0, 0);
        push(hs[2], 1, 8'h1C, 0, 0, 1);
        push(hs[3], 1, 8'h32, 0, 1, 2);
        push(hs[4], 0, 8'h00, 0, 0, 0);
        push(hs[5], 1, 8'h32, 0, 0, 2);
        wait_empty(60);
        repeat (4) @(negedge clk);
        chk("hs_pops", 64'(pops - p0), 64'd6);
        chk("hs_lows", 64'(lows - l0), 64'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("hs_byte%0d", i), 64'(popped[popped.size() - 6 + i]), 64'(hs[i]));
        chk("hs_final", {key_code, key_down, press_count}, {8'h32, 1'b0, 8'd2});

        // 256 distinct presses wrap the counter.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            code = (i % 2 == 0) ? 8'h1C : 8'h32;
            push(code, 1, code, 0, 1, 8'(i + 1));
            push(8'hF0, 0, 8'h00, 0, 0, 0);
            push(code, 1, code, 0, 0, 8'(i + 1));
        end
        wait_empty(2500);
        repeat (2) @(negedge clk);
        chk("wrap_count", {key_code, key_down, press_count}, {8'h32, 1'b0, 8'h00});
        chk("wrap_events_left", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a pop.
        push(8'h2B, 1, 8'h2B, 0, 1, 8'h01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.nextdata_n && n < 20);
        chk("midpop_seen", {31'd0, bus.nextdata_n}, 32'd0);
        #2 clrn = 1'b0;
        #1;
        chk("midpop_reset", {key_code, key_ext, key_down, key_event, press_count, shift,
                             bus.nextdata_n}, {8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);
        chk("after_reset_idle", {key_code, key_down, press_count, bus.nextdata_n},
            {8'h00, 1'b0, 8'h00, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
